lcd1602_writer: RTL and testbench
=================================

Name: lcd1602_writer

Overview:
- Downstream consumer of the data stage's LCD1602 character content; owns the RS/RW/E/DB pins of the LCD1602 module.
- After power-on it runs the HD44780 8-bit initialisation sequence. It then writes a 32-character frame (two lines of 16) from a flat character buffer, and rewrites the frame on each refresh request.
- All E-pulse and command-wait timing comes from cycle counters on the 1 MHz system clock.

Parameters:
- T_POR, 15000, cycles to wait after reset release before the first command (15 ms).
- T_SU, 2, cycles that RS/DB are stable with E low before E rises.
- T_EH, 2, cycles E is held high.
- T_H, 1, cycles after E falls with RS/DB still held.
- T_CMD, 40, wait cycles after a normal command or data write.
- T_CLR, 1640, wait cycles after the clear-display command (0x01).

Ports:
- clk, input, 1, system clock (1 MHz).
- rst, input, 1, asynchronous reset, active-low.
- char_data, input, 256, character buffer. Char i (0..31) is at bits [8i+7:8i]; i=0..15 is line 1, i=16..31 is line 2.
- refresh, input, 1, request to rewrite the frame; single-cycle pulse or level.
- rs, output, 1, LCD register select (0 = command, 1 = data).
- rw, output, 1, LCD read/write; always 0 (write only, busy flag never polled).
- e, output, 1, LCD enable.
- db, output, 8, LCD data bus.
- busy, output, 1, high while init or a frame is in progress.
- frame_done, output, 1, one-cycle pulse when the last byte's wait completes.

Behaviour:
- Reset values (rst=0, asynchronous): rs=0, rw=0, e=0, db=8'h00, busy=1, frame_done=0, pending=0, state=POR, all counters=0.
- Top FSM states:
  - POR: count T_POR cycles, then go to INIT.
  - INIT: issue 0x38, 0x0C, 0x06, 0x01 as commands (rs=0), in that order.
  - ADDR1: command 0x80.
  - LINE1: data chars 0..15 (rs=1).
  - ADDR2: command 0xC0.
  - LINE2: data chars 16..31.
  - IDLE.
- Byte-write sub-sequence, identical for every byte:
  - SETUP: T_SU cycles. rs/db are driven, e=0.
  - PULSE: T_EH cycles, e=1.
  - HOLD: T_H cycles, e=0.
  - WAIT: T_CLR cycles after 0x01, otherwise T_CMD.
  - Total cycles per byte = T_SU + T_EH + T_H + wait.
- rs and db change only on the first cycle of SETUP. They stay constant through HOLD and retain their value through WAIT and IDLE.
- A data byte is sampled from char_data on the first SETUP cycle of that byte. Buffer changes at any other time do not affect the byte in flight.
- Frame order is fixed at 34 bytes: 0x80, chars 0..15, 0xC0, chars 16..31.
  - The first frame after reset follows INIT directly, giving 38 E pulses total from reset.
  - Later frames skip POR and INIT.
- frame_done pulses on the last WAIT cycle of char 31. On the next cycle the FSM is in IDLE with busy=0, or starts a new frame if pending=1.
- refresh handling:
  - refresh=1 on any cycle sets pending.
  - In IDLE with pending (or refresh) set, ADDR1 SETUP begins on the next cycle and pending clears.
  - A refresh during POR, INIT or a frame is remembered and serviced immediately after the current frame. Multiple requests collapse into one.
  - A held-high refresh gives back-to-back frames.
- busy=0 only in IDLE. busy rises in the same cycle the FSM leaves IDLE.
- Reset asserted mid-operation: all outputs go immediately to reset values. After release the full POR + INIT sequence reruns. Any partial frame is abandoned, including an E pulse cut short.
- Counters are sized for the largest parameter. A counter is never compared against 0-length phases: a zero-valued parameter is illegal.

Test Plan:
- Small parameters (T_POR=10, T_SU=1, T_EH=2, T_H=1, T_CMD=3, T_CLR=8), release reset, refresh=0 -> e stays 0 for 10 cycles, then 38 E pulses. The db sequence is 38,0C,06,01,80,c0..c15,C0,c16..c31. rs=0 on the four init bytes and both address bytes. busy falls and frame_done pulses once.
- Same setup -> the gap from the E fall of 0x01 to the next SETUP is exactly T_H+T_CLR. Every other byte period is exactly 7 cycles. rs/db never change while e=1.
- Pulse refresh in IDLE with char_data="HELLO..." -> 34 pulses with no init bytes. db of pulse 2 = 0x48 ('H'). busy returns to 0 after frame_done.
- Pulse refresh twice during a frame -> exactly one extra frame follows, starting the cycle after frame_done, with no IDLE cycle between.
- Change char_data[7:0] from 0x41 to 0x42 while char 0 is in PULSE -> that frame writes 0x41; the next frame writes 0x42.
- Assert rst low while e=1 mid-frame -> e, rs, db drop to 0 that cycle and busy=1. After release, 10 idle cycles then the full 38-pulse sequence.

Source files
------------

// File: rtl/lcd1602_writer.sv
// LCD1602 (HD44780) 8-bit writer: power-on wait, init sequence, then 32-character frames
// written from a flat buffer, with all bus timing derived from cycle counters.
module lcd1602_writer #(
    parameter int T_POR = 15000,
    parameter int T_SU  = 2,
    parameter int T_EH  = 2,
    parameter int T_H   = 1,
    parameter int T_CMD = 40,
    parameter int T_CLR = 1640
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] char_data,
    input  logic         refresh,
    output logic         rs,
    output logic         rw,
    output logic         e,
    output logic [7:0]   db,
    output logic         busy,
    output logic         frame_done
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_T = max2(max2(max2(T_POR, T_SU), max2(T_EH, T_H)), max2(T_CMD, T_CLR));
    localparam int CW    = $clog2(MAX_T + 1);

    typedef enum logic [2:0] {
        ST_POR, ST_INIT, ST_ADDR1, ST_LINE1, ST_ADDR2, ST_LINE2, ST_IDLE
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP, PH_PULSE, PH_HOLD, PH_WAIT
    } phase_t;

    function automatic logic is_byte_state(input state_t st);
        return (st == ST_INIT) || (st == ST_ADDR1) || (st == ST_LINE1) ||
               (st == ST_ADDR2) || (st == ST_LINE2);
    endfunction

    function automatic logic [7:0] byte_for(input state_t st, input logic [3:0] idx,
                                            input logic [255:0] buf_v);
        logic [7:0] b;
        b = 8'h00;
        case (st)
            ST_INIT: begin
                case (idx)
                    4'd0:    b = 8'h38;
                    4'd1:    b = 8'h0C;
                    4'd2:    b = 8'h06;
                    default: b = 8'h01;
                endcase
            end
            ST_ADDR1: b = 8'h80;
            ST_LINE1: b = buf_v[{1'b0, idx, 3'b000} +: 8];
            ST_ADDR2: b = 8'hC0;
            ST_LINE2: b = buf_v[{1'b1, idx, 3'b000} +: 8];
            default:  b = 8'h00;
        endcase
        return b;
    endfunction

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic            pending_q, pending_d;
    logic            rs_q, rs_d;
    logic            e_q, e_d;
    logic [7:0]      db_q, db_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic [CW-1:0]   phase_len_s;
    logic            last_s;
    logic            req_s;

    // Length of the phase currently being timed; the clear command needs the long wait.
    always_comb begin
        phase_len_s = CW'(T_CMD);
        if (state_q == ST_POR) begin
            phase_len_s = CW'(T_POR);
        end else begin
            case (phase_q)
                PH_SETUP: phase_len_s = CW'(T_SU);
                PH_PULSE: phase_len_s = CW'(T_EH);
                PH_HOLD:  phase_len_s = CW'(T_H);
                default:  phase_len_s = ((state_q == ST_INIT) && (idx_q == 4'd3)) ?
                                        CW'(T_CLR) : CW'(T_CMD);
            endcase
        end
    end

    // Next-state logic for the sequence FSM, byte phases and request latch.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        req_s     = pending_q | refresh;
        pending_d = req_s;
        last_s    = (cnt_q == (phase_len_s - CW'(1)));
        case (state_q)
            ST_POR: begin
                if (last_s) begin
                    state_d = ST_INIT;
                    phase_d = PH_SETUP;
                    idx_d   = 4'd0;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_IDLE: begin
                cnt_d = {CW{1'b0}};
                if (req_s) begin
                    state_d   = ST_ADDR1;
                    phase_d   = PH_SETUP;
                    idx_d     = 4'd0;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (!last_s) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = {CW{1'b0}};
                    case (phase_q)
                        PH_SETUP: phase_d = PH_PULSE;
                        PH_PULSE: phase_d = PH_HOLD;
                        PH_HOLD:  phase_d = PH_WAIT;
                        default: begin
                            phase_d = PH_SETUP;
                            case (state_q)
                                ST_INIT: begin
                                    if (idx_q == 4'd3) begin
                                        state_d = ST_ADDR1;
                                        idx_d   = 4'd0;
                                    end else begin
                                        idx_d = idx_q + 4'd1;
                                    end
                                end
                                ST_ADDR1: begin
                                    state_d = ST_LINE1;
                                    idx_d   = 4'd0;
                                end
                                ST_LINE1: begin
                                    if (idx_q == 4'd15) begin
                                        state_d = ST_ADDR2;
                                        idx_d   = 4'd0;
                                    end else begin
                                        idx_d = idx_q + 4'd1;
                                    end
                                end
                                ST_ADDR2: begin
                                    state_d = ST_LINE2;
                                    idx_d   = 4'd0;
                                end
                                ST_LINE2: begin
                                    if (idx_q != 4'd15) begin
                                        idx_d = idx_q + 4'd1;
                                    end else if (req_s) begin
                                        state_d   = ST_ADDR1;
                                        idx_d     = 4'd0;
                                        pending_d = 1'b0;
                                    end else begin
                                        state_d = ST_IDLE;
                                        idx_d   = 4'd0;
                                    end
                                end
                                default: state_d = ST_IDLE;
                            endcase
                        end
                    endcase
                end
            end
        endcase
    end

    // Pin values are derived from the next state so they are registered yet aligned with it;
    // a byte is latched only on entry to SETUP, which is the only time cnt_d is zero there.
    always_comb begin
        rs_d = rs_q;
        db_d = db_q;
        if (is_byte_state(state_d) && (phase_d == PH_SETUP) && (cnt_d == {CW{1'b0}})) begin
            rs_d = (state_d == ST_LINE1) || (state_d == ST_LINE2);
            db_d = byte_for(state_d, idx_d, char_data);
        end else begin
            rs_d = rs_q;
        end
        e_d          = is_byte_state(state_d) && (phase_d == PH_PULSE);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_LINE2) && (idx_d == 4'd15) &&
                       (phase_d == PH_WAIT) && (cnt_d == CW'(T_CMD - 1));
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_POR;
            phase_q      <= PH_SETUP;
            cnt_q        <= {CW{1'b0}};
            idx_q        <= 4'd0;
            pending_q    <= 1'b0;
            rs_q         <= 1'b0;
            e_q          <= 1'b0;
            db_q         <= 8'h00;
            busy_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            rs_q         <= rs_d;
            e_q          <= e_d;
            db_q         <= db_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rs         = rs_q;
    assign rw         = 1'b0;
    assign e          = e_q;
    assign db         = db_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd1602_writer.sv
// Scoreboard bench for lcd1602_writer: expected bytes/periods queued at stimulus time,
// popped and compared on every E rising edge.
module tb_lcd1602_writer;

    localparam int P_POR   = 10;
    localparam int P_SU    = 1;
    localparam int P_EH    = 2;
    localparam int P_H     = 1;
    localparam int P_CMD   = 3;
    localparam int P_CLR   = 8;
    localparam int PER     = P_SU + P_EH + P_H + P_CMD;
    localparam int PER_CLR = P_SU + P_EH + P_H + P_CLR;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [255:0] char_data = 256'h0;
    logic         refresh = 1'b0;
    logic         rs, rw, e, busy, frame_done;
    logic [7:0]   db;

    always #5 clk = ~clk;

    lcd1602_writer #(
        .T_POR(P_POR), .T_SU(P_SU), .T_EH(P_EH), .T_H(P_H), .T_CMD(P_CMD), .T_CLR(P_CLR)
    ) dut (
        .clk(clk), .rst(rst), .char_data(char_data), .refresh(refresh),
        .rs(rs), .rw(rw), .e(e), .db(db), .busy(busy), .frame_done(frame_done)
    );

    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         per;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_rise = 0;
    int   rises = 0;
    int   fd_cnt = 0;
    int   stab_err = 0;
    int   rw_err = 0;
    logic prev_e = 1'b0;
    logic [8:0] held = 9'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: pops one expectation per E rise and watches bus stability while E is high.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rw !== 1'b0) rw_err++;
            if (rst) begin
                if (frame_done === 1'b1) fd_cnt++;
                if (e === 1'b1 && prev_e == 1'b0) begin
                    rises++;
                    if (sb.size() == 0) begin
                        check_eq("extra_pulse", 32'd1, 32'd0);
                    end else begin
                        x = sb.pop_front();
                        check_eq("pulse_rs", {31'd0, rs}, {31'd0, x.rs});
                        check_eq("pulse_db", {24'd0, db}, {24'd0, x.db});
                        if (x.per != 0) check_eq("pulse_period", cyc - last_rise, x.per);
                    end
                    last_rise = cyc;
                    held = {rs, db};
                end else if (e === 1'b1 && {rs, db} !== held) begin
                    stab_err++;
                end
                prev_e = e;
            end else begin
                prev_e = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic r, input logic [7:0] d, input int p);
        exp_t x;
        x.rs = r;
        x.db = d;
        x.per = p;
        sb.push_back(x);
    endtask

    task automatic push_init();
        push(1'b0, 8'h38, 0);
        push(1'b0, 8'h0C, PER);
        push(1'b0, 8'h06, PER);
        push(1'b0, 8'h01, PER);
    endtask

    task automatic push_frame(input logic [255:0] cd, input int first_per);
        push(1'b0, 8'h80, first_per);
        for (int i = 0; i < 16; i++) push(1'b1, cd[8*i +: 8], PER);
        push(1'b0, 8'hC0, PER);
        for (int i = 16; i < 32; i++) push(1'b1, cd[8*i +: 8], PER);
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
    endtask

    task automatic release_and_measure(input string tag);
        int n;
        rst = 1'b1;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            n++;
            if (e === 1'b1) break;
        end
        check_eq({tag, "_first_e"}, n, P_POR + P_SU);
    endtask

    task automatic wait_fd(input string tag);
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (frame_done === 1'b1) break;
        end
        check_eq({tag, "_fd"}, {31'd0, frame_done}, 32'd1);
        tick();
        check_eq({tag, "_fd_pulse"}, {31'd0, frame_done}, 32'd0);
    endtask

    task automatic wait_rises(input int target);
        for (int k = 0; k < 2000; k++) begin
            if (rises >= target) break;
            tick();
        end
        check_eq("rise_reached", {31'd0, (rises >= target)}, 32'd1);
    endtask

    task automatic rand_chars();
        for (int i = 0; i < 8; i++) char_data[32*i +: 32] = $urandom;
    endtask

    initial begin
        string s;
        int    r0;

        // Reset values
        repeat (3) tick();
        check_eq("rst_e", {31'd0, e}, 32'd0);
        check_eq("rst_rs", {31'd0, rs}, 32'd0);
        check_eq("rst_db", {24'd0, db}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd1);
        check_eq("rst_fd", {31'd0, frame_done}, 32'd0);

        // Power-on init followed by the first frame
        rand_chars();
        push_init();
        push_frame(char_data, PER_CLR);
        release_and_measure("por1");
        wait_fd("frame1");
        check_eq("frame1_idle", {31'd0, busy}, 32'd0);
        check_eq("frame1_sb_empty", sb.size(), 32'd0);
        check_eq("frame1_fd_cnt", fd_cnt, 32'd1);
        repeat (5) tick();
        check_eq("idle_stays", {31'd0, busy}, 32'd0);

        // Refresh from IDLE with a text buffer
        s = "HELLO LCD1602!!!WORLD OF CHARS..";
        for (int i = 0; i < 32; i++) char_data[8*i +: 8] = s[i];
        push_frame(char_data, 0);
        r0 = rises;
        pulse_refresh();
        check_eq("start_busy", {31'd0, busy}, 32'd1);
        check_eq("start_db", {24'd0, db}, 32'h80);
        check_eq("start_e", {31'd0, e}, 32'd0);
        wait_rises(r0 + 2);
        check_eq("hello_H", {24'd0, db}, 32'h48);
        wait_fd("hello");
        check_eq("hello_idle", {31'd0, busy}, 32'd0);

        // Two refreshes during a frame collapse into one back-to-back frame
        rand_chars();
        push_frame(char_data, 0);
        push_frame(char_data, PER);
        r0 = rises;
        pulse_refresh();
        wait_rises(r0 + 5);
        pulse_refresh();
        wait_rises(r0 + 10);
        pulse_refresh();
        wait_fd("b2b_a");
        check_eq("b2b_no_idle", {31'd0, busy}, 32'd1);
        check_eq("b2b_addr", {24'd0, db}, 32'h80);
        wait_fd("b2b_b");
        check_eq("b2b_idle", {31'd0, busy}, 32'd0);
        repeat (20) tick();
        check_eq("b2b_sb_empty", sb.size(), 32'd0);

        // Buffer change while char 0 is in PULSE only affects the next frame
        char_data[7:0] = 8'h41;
        push_frame(char_data, 0);
        r0 = rises;
        pulse_refresh();
        wait_rises(r0 + 2);
        check_eq("chg_db41", {24'd0, db}, 32'h41);
        char_data[7:0] = 8'h42;
        push_frame(char_data, PER);
        pulse_refresh();
        wait_fd("chg_a");
        wait_fd("chg_b");
        check_eq("chg_idle", {31'd0, busy}, 32'd0);

        // Reset mid-pulse abandons the frame and reruns POR + INIT
        push_frame(char_data, 0);
        r0 = rises;
        pulse_refresh();
        wait_rises(r0 + 6);
        check_eq("mid_e_high", {31'd0, e}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_e", {31'd0, e}, 32'd0);
        check_eq("mid_rst_rs", {31'd0, rs}, 32'd0);
        check_eq("mid_rst_db", {24'd0, db}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd1);
        sb.delete();
        repeat (3) tick();
        push_init();
        push_frame(char_data, PER_CLR);
        release_and_measure("por2");
        wait_fd("frame_rst");
        check_eq("frame_rst_idle", {31'd0, busy}, 32'd0);

        repeat (10) tick();
        check_eq("final_sb_empty", sb.size(), 32'd0);
        check_eq("bus_stable_e_high", stab_err, 32'd0);
        check_eq("rw_low", rw_err, 32'd0);
        check_eq("fd_total", fd_cnt, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
